// File: rtl/mem_copy_dma_if.sv
// Memory bus between an initiator and the 256-address memory map:
// one-cycle synchronous read, write on the clock edge while mem_write is high.
interface mem_copy_dma_if;
  logic [7:0] mem_address;
  logic [7:0] mem_data_in;
  logic       mem_write;
  logic [7:0] mem_data_out;

  modport master (
    output mem_address,
    output mem_data_in,
    output mem_write,
    input  mem_data_out
  );

  modport slave (
    input  mem_address,
    input  mem_data_in,
    input  mem_write,
    output mem_data_out
  );
endinterface

// File: rtl/mem_copy_dma.sv
// Bus-master copy engine: FETCH/CAPTURE/STORE per byte, src/dst pointers wrap mod 256.
// Optional constant-fill mode when MEM_COPY_FILL_EN is defined (adds fill, fill_value, FILL state).
module mem_copy_dma (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       src_addr,
  input  logic [7:0]       dst_addr,
  input  logic [7:0]       length,
`ifdef MEM_COPY_FILL_EN
  input  logic             fill,
  input  logic [7:0]       fill_value,
`endif
  mem_copy_dma_if.master   bus,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_STORE   = 3'd3,
    S_DONE    = 3'd4
`ifdef MEM_COPY_FILL_EN
    ,
    S_FILL    = 3'd5
`endif
  } state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_src_ptr, w_src_ptr_next;
  logic [7:0] r_dst_ptr, w_dst_ptr_next;
  logic [7:0] r_count, w_count_next;
  logic [7:0] r_buf, w_buf_next;
`ifdef MEM_COPY_FILL_EN
  logic       r_fill, w_fill_next;
  logic [7:0] r_fill_value, w_fill_value_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_src_ptr    <= 8'h00;
      r_dst_ptr    <= 8'h00;
      r_count      <= 8'h00;
      r_buf        <= 8'h00;
`ifdef MEM_COPY_FILL_EN
      r_fill       <= 1'b0;
      r_fill_value <= 8'h00;
`endif
    end else begin
      r_state      <= w_state_next;
      r_src_ptr    <= w_src_ptr_next;
      r_dst_ptr    <= w_dst_ptr_next;
      r_count      <= w_count_next;
      r_buf        <= w_buf_next;
`ifdef MEM_COPY_FILL_EN
      r_fill       <= w_fill_next;
      r_fill_value <= w_fill_value_next;
`endif
    end
  end

  // Outputs depend only on registered state, so no input reaches them combinationally.
  always_comb begin
    w_state_next      = r_state;
    w_src_ptr_next    = r_src_ptr;
    w_dst_ptr_next    = r_dst_ptr;
    w_count_next      = r_count;
    w_buf_next        = r_buf;
`ifdef MEM_COPY_FILL_EN
    w_fill_next       = r_fill;
    w_fill_value_next = r_fill_value;
`endif
    bus.mem_address   = 8'h00;
    bus.mem_data_in   = 8'h00;
    bus.mem_write     = 1'b0;
    busy              = 1'b0;
    done              = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_src_ptr_next = src_addr;
          w_dst_ptr_next = dst_addr;
          w_count_next   = length;
`ifdef MEM_COPY_FILL_EN
          w_fill_next       = fill;
          w_fill_value_next = fill_value;
          if (length == 8'h00)
            w_state_next = S_DONE;
          else if (fill)
            w_state_next = S_FILL;
          else
            w_state_next = S_FETCH;
`else
          w_state_next = (length == 8'h00) ? S_DONE : S_FETCH;
`endif
        end
      end
      S_FETCH: begin
        busy            = 1'b1;
        bus.mem_address = r_src_ptr;
        w_state_next    = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Address held so the memory's output mux keeps selecting the source region.
        busy            = 1'b1;
        bus.mem_address = r_src_ptr;
        w_buf_next      = bus.mem_data_out;
        w_state_next    = S_STORE;
      end
      S_STORE: begin
        busy            = 1'b1;
        bus.mem_address = r_dst_ptr;
        bus.mem_data_in = r_buf;
        bus.mem_write   = 1'b1;
        w_src_ptr_next  = r_src_ptr + 8'd1;
        w_dst_ptr_next  = r_dst_ptr + 8'd1;
        w_count_next    = r_count - 8'd1;
        w_state_next    = (r_count == 8'd1) ? S_DONE : S_FETCH;
      end
`ifdef MEM_COPY_FILL_EN
      S_FILL: begin
        busy            = 1'b1;
        bus.mem_address = r_dst_ptr;
        bus.mem_data_in = r_fill_value;
        bus.mem_write   = 1'b1;
        w_dst_ptr_next  = r_dst_ptr + 8'd1;
        w_count_next    = r_count - 8'd1;
        w_state_next    = (r_count == 8'd1) ? S_DONE : S_FILL;
      end
`endif
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a behavioural model of the 256-address memory map.
module tb_mem_copy_dma;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] src_addr, dst_addr, length;
  logic       fill;
  logic [7:0] fill_value;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem      [256];
  logic [7:0] init_mem [256];
  logic       load_mem;
  logic [7:0] rd_q;

  mem_copy_dma_if bus ();

  mem_copy_dma dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
`ifdef MEM_COPY_FILL_EN
    .fill       (fill),
    .fill_value (fill_value),
`endif
    .bus        (bus.master),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Memory: registered read; writes land only in RWM (80-DF) and output ports (E0-EF).
  assign bus.mem_data_out = rd_q;
  always @(posedge clk) begin
    rd_q <= mem[bus.mem_address];
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
    end else if (bus.mem_write && bus.mem_address >= 8'h80 && bus.mem_address <= 8'hEF) begin
      mem[bus.mem_address] <= bus.mem_data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                     input logic f, input logic [7:0] fv,
                     output int done_cyc, output int busy_n, output int write_n, output int read_n);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; length = l; fill = f; fill_value = fv;
    @(posedge clk);
    done_cyc = -1; busy_n = 0; write_n = 0; read_n = 0;
    for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
      if (bus.mem_write) write_n++;
      if (busy && !bus.mem_write) read_n++;
      if (done) done_cyc = c;
    end
    $display("copy src=%02h dst=%02h len=%0d fill=%0b: done at cycle %0d, busy %0d, writes %0d, reads %0d",
             s, d, l, f, done_cyc, busy_n, write_n, read_n);
  endtask

  int dc, bn, wn, rn;

  initial begin
    for (int i = 0; i < 256; i++) init_mem[i] = (i < 128) ? (8'(i) ^ 8'h3C) : 8'h00;
    for (int i = 240; i < 256; i++) init_mem[i] = 8'(i);
    init_mem[8'h00] = 8'hC3;
    init_mem[8'h10] = 8'h11; init_mem[8'h11] = 8'h22;
    init_mem[8'h12] = 8'h33; init_mem[8'h13] = 8'h44;
    init_mem[8'hF3] = 8'h5A; init_mem[8'hFE] = 8'h7E; init_mem[8'hFF] = 8'h7F;

    reset = 1'b1; load_mem = 1'b1; start = 1'b0;
    src_addr = 8'h00; dst_addr = 8'h00; length = 8'h00; fill = 1'b0; fill_value = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_addr",  32'(bus.mem_address), 32'h00);
    check("reset_din",   32'(bus.mem_data_in), 32'h00);
    check("reset_write", 32'(bus.mem_write),   32'h0);
    check("reset_busy",  32'(busy),            32'h0);
    check("reset_done",  32'(done),            32'h0);
    reset = 1'b0; load_mem = 1'b0;

    // ROM 10..13 -> RWM 90..93
    run(8'h10, 8'h90, 8'd4, 1'b0, 8'h00, dc, bn, wn, rn);
    check("copy4_done_cycle", 32'(dc), 32'd13);
    check("copy4_busy",       32'(bn), 32'd12);
    check("copy4_writes",     32'(wn), 32'd4);
    check("copy4_m90", 32'(mem[8'h90]), 32'h11);
    check("copy4_m91", 32'(mem[8'h91]), 32'h22);
    check("copy4_m92", 32'(mem[8'h92]), 32'h33);
    check("copy4_m93", 32'(mem[8'h93]), 32'h44);
    check("copy4_m94", 32'(mem[8'h94]), 32'h00);

    run(8'h10, 8'h98, 8'd0, 1'b0, 8'h00, dc, bn, wn, rn);
    check("len0_done_cycle", 32'(dc), 32'd1);
    check("len0_busy",       32'(bn), 32'd0);
    check("len0_writes",     32'(wn), 32'd0);
    check("len0_m98",        32'(mem[8'h98]), 32'h00);

    // Both pointers wrap: reads FE, FF, 00; writes DE, DF, E0
    run(8'hFE, 8'hDE, 8'd3, 1'b0, 8'h00, dc, bn, wn, rn);
    check("wrap_done_cycle", 32'(dc), 32'd10);
    check("wrap_mDE", 32'(mem[8'hDE]), 32'h7E);
    check("wrap_mDF", 32'(mem[8'hDF]), 32'h7F);
    check("wrap_mE0", 32'(mem[8'hE0]), 32'hC3);

    run(8'hF3, 8'hE7, 8'd1, 1'b0, 8'h00, dc, bn, wn, rn);
    check("port_done_cycle", 32'(dc), 32'd4);
    check("port_mE7",        32'(mem[8'hE7]), 32'h5A);

    // Write to ROM is issued but ignored by memory
    run(8'h90, 8'h05, 8'd1, 1'b0, 8'h00, dc, bn, wn, rn);
    check("romwr_writes", 32'(wn), 32'd1);
    check("romwr_m05",    32'(mem[8'h05]), 32'h39);

    // 8-byte copy, ignored start in cycle 2, reset ahead of the 4th STORE
    @(negedge clk);
    start = 1'b1; src_addr = 8'h20; dst_addr = 8'hA0; length = 8'd8; fill = 1'b0;
    @(posedge clk);
    wn = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = (c == 2);
      if (c == 2) begin src_addr = 8'h10; dst_addr = 8'hB0; length = 8'd1; end
      if (bus.mem_write) wn++;
      if (c == 11) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    $display("abort copy: writes before reset %0d, after reset write=%0b busy=%0b done=%0b",
             wn, bus.mem_write, busy, done);
    check("abort_writes_before", 32'(wn), 32'd3);
    check("abort_write", 32'(bus.mem_write), 32'h0);
    check("abort_busy",  32'(busy), 32'h0);
    check("abort_done",  32'(done), 32'h0);
    check("abort_addr",  32'(bus.mem_address), 32'h00);
    check("abort_mA0", 32'(mem[8'hA0]), 32'h1C);
    check("abort_mA1", 32'(mem[8'hA1]), 32'h1D);
    check("abort_mA2", 32'(mem[8'hA2]), 32'h1E);
    check("abort_mA3", 32'(mem[8'hA3]), 32'h00);
    check("abort_mB0", 32'(mem[8'hB0]), 32'h00);
    bn = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done) bn++;
    end
    check("abort_stays_idle", 32'(bn), 32'd0);

`ifdef MEM_COPY_FILL_EN
    run(8'h10, 8'h80, 8'd5, 1'b1, 8'hA5, dc, bn, wn, rn);
    check("fill_done_cycle", 32'(dc), 32'd6);
    check("fill_busy",       32'(bn), 32'd5);
    check("fill_reads",      32'(rn), 32'd0);
    for (int i = 0; i < 5; i++) check("fill_mem", 32'(mem[8'h80 + i]), 32'hA5);
    check("fill_m85", 32'(mem[8'h85]), 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
